// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage with ALU control decode, operand-B select and a one-entry result buffer

module alu (
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [2:0]  control,
  output logic [31:0] result_out,
  output logic        zero_out
);
  // 3-bit control selects and/or/add/sub/signed set-on-less-than
  always_comb begin
    result_out = control == 3'b000 ? a_in & b_in :
                 control == 3'b001 ? a_in | b_in :
                 control == 3'b110 ? a_in - b_in :
                 control == 3'b111 ? {31'b0, $signed(a_in) < $signed(b_in)} :
                 a_in + b_in;
    zero_out = result_out == 32'b0;
  end
endmodule

module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [1:0]       alu_op_in,
  input  logic [5:0]       funct_in,
  input  logic [WIDTH-1:0] rs_in,
  input  logic [WIDTH-1:0] rt_in,
  input  logic [15:0]      imm_in,
  input  logic             alu_src_in,
  input  logic             flush_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] result_out,
  output logic             zero_out,
  output logic             illegal_out,
  output logic [CNT_W-1:0] op_count_out
);
  logic [2:0]       w_ctrl;
  logic             w_illegal;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_result;
  logic             w_zero;
  logic             w_accept;
  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  // ALUOp/funct decode; undefined encodings fall back to add and raise illegal
  always_comb begin
    w_ctrl = 3'b010;
    w_illegal = 1'b0;
    if (alu_op_in == 2'b01) w_ctrl = 3'b110;
    else if (alu_op_in == 2'b11) w_illegal = 1'b1;
    else if (alu_op_in == 2'b10)
      case (funct_in)
        6'b100000: w_ctrl = 3'b010;
        6'b100010: w_ctrl = 3'b110;
        6'b100100: w_ctrl = 3'b000;
        6'b100101: w_ctrl = 3'b001;
        6'b101010: w_ctrl = 3'b111;
        default:   w_illegal = 1'b1;
      endcase
  end

  assign w_b       = alu_src_in ? {{(WIDTH-16){imm_in[15]}}, imm_in} : rt_in;
  assign ready_out = !r_valid || ready_in;
  assign w_accept  = valid_in && ready_out && !flush_in;

  alu u_alu (
    .a_in      (rs_in),
    .b_in      (w_b),
    .control   (w_ctrl),
    .result_out(w_result),
    .zero_out  (w_zero)
  );

  // result buffer: load on accept, drain on downstream ready, drop on flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (flush_in) r_valid <= 1'b0;
      else if (w_accept) r_valid <= 1'b1;
      else if (ready_in) r_valid <= 1'b0;
      if (w_accept) begin
        r_result  <= w_result;
        r_zero    <= w_zero;
        r_illegal <= w_illegal;
      end
    end
  end

  // completed-op counter: counts every downstream handshake, flush included
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_count <= '0;
    else if (r_valid && ready_in) r_count <= r_count + CNT_W'(1);
  end

  assign valid_out    = r_valid;
  assign result_out   = r_result;
  assign zero_out     = r_zero;
  assign illegal_out  = r_illegal;
  assign op_count_out = r_count;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed and random checks of alu_exec_stage against a behavioural model
module tb_alu_exec_stage;
  localparam int W  = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic [1:0]    alu_op_in = '0;
  logic [5:0]    funct_in = '0;
  logic [W-1:0]  rs_in = '0;
  logic [W-1:0]  rt_in = '0;
  logic [15:0]   imm_in = '0;
  logic          alu_src_in = 1'b0;
  logic          flush_in = 1'b0;
  logic          valid_out;
  logic          ready_in = 1'b0;
  logic [W-1:0]  result_out;
  logic          zero_out;
  logic          illegal_out;
  logic [CW-1:0] op_count_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic          m_valid = 1'b0;
  logic [31:0]   m_res = '0;
  logic          m_zero = 1'b0;
  logic          m_ill = 1'b0;
  logic [CW-1:0] m_count = '0;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
    .alu_op_in(alu_op_in), .funct_in(funct_in), .rs_in(rs_in), .rt_in(rt_in),
    .imm_in(imm_in), .alu_src_in(alu_src_in), .flush_in(flush_in),
    .valid_out(valid_out), .ready_in(ready_in), .result_out(result_out),
    .zero_out(zero_out), .illegal_out(illegal_out), .op_count_out(op_count_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ref_op(input logic [1:0] op, input logic [5:0] f,
                                         input logic [31:0] a, input logic [31:0] b);
    if (op == 2'd0) return {1'b0, a + b};
    if (op == 2'd1) return {1'b0, a - b};
    if (op == 2'd3) return {1'b1, a + b};
    if (f == 6'h20) return {1'b0, a + b};
    if (f == 6'h22) return {1'b0, a - b};
    if (f == 6'h24) return {1'b0, a & b};
    if (f == 6'h25) return {1'b0, a | b};
    if (f == 6'h2a) return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
    return {1'b1, a + b};
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                       input logic src, input logic rdy, input logic fl);
    valid_in = v; alu_op_in = op; funct_in = f; rs_in = a; rt_in = b;
    imm_in = imm; alu_src_in = src; ready_in = rdy; flush_in = fl;
  endtask

  task automatic cycle();
    logic [32:0] r;
    logic [31:0] b;
    logic rdy;
    #1;
    rdy = !m_valid || ready_in;
    chk("ready_out", ready_out, rdy);
    @(posedge clk);
    b = alu_src_in ? {{16{imm_in[15]}}, imm_in} : rt_in;
    r = ref_op(alu_op_in, funct_in, rs_in, b);
    if (m_valid && ready_in) m_count = CW'((int'(m_count) + 1) % (1 << CW));
    if (flush_in) m_valid = 1'b0;
    else if (valid_in && rdy) begin
      m_valid = 1'b1; m_res = r[31:0]; m_ill = r[32]; m_zero = (r[31:0] == 0);
    end else if (ready_in) m_valid = 1'b0;
    #1;
    chk("valid_out", valid_out, m_valid);
    chk("op_count", op_count_out, m_count);
    if (m_valid) begin
      chk("result", result_out, m_res);
      chk("zero", zero_out, m_zero);
      chk("illegal", illegal_out, m_ill);
    end
  endtask

  initial begin
    logic [31:0] held_res;
    logic [CW-1:0] held_cnt;
    logic [5:0] fsel [6];
    fsel[0] = 6'h20; fsel[1] = 6'h22; fsel[2] = 6'h24;
    fsel[3] = 6'h25; fsel[4] = 6'h2a; fsel[5] = 6'h07;
    #2;
    chk("rst_valid", valid_out, 0);
    chk("rst_result", result_out, 0);
    chk("rst_count", op_count_out, 0);
    chk("rst_ready", ready_out, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    drive(1, 2'd0, 0, 32'h00ff00ff, 32'h11111111, 0, 0, 1, 0); cycle();
    chk("add_res", result_out, 32'h12101210);
    chk("add_zero", zero_out, 0);
    drive(0, 2'd0, 0, 0, 0, 0, 0, 1, 0); cycle();
    chk("add_count", op_count_out, 1);

    drive(1, 2'd1, 0, 32'h0, 32'h1, 0, 0, 1, 0); cycle();
    chk("sub_res", result_out, 32'hffffffff);
    drive(1, 2'd0, 0, 32'h5, 32'h0, 16'hfffb, 1, 1, 0); cycle();
    chk("imm_res", result_out, 32'h0);
    chk("imm_zero", zero_out, 1);
    drive(0, 2'd0, 0, 0, 0, 0, 0, 1, 0); cycle();

    drive(1, 2'd2, 6'h24, 32'h0f0f0f0f, 32'hffffffff, 0, 0, 1, 0); cycle();
    chk("and_res", result_out, 32'h0f0f0f0f);
    drive(1, 2'd2, 6'h25, 32'h0f0f0f0f, 32'hf0f0f0f0, 0, 0, 1, 0); cycle();
    chk("or_res", result_out, 32'hffffffff);
    drive(1, 2'd2, 6'h2a, 32'hffffffff, 32'h0fffffff, 0, 0, 1, 0); cycle();
    chk("slt1_res", result_out, 32'h1);
    drive(1, 2'd2, 6'h2a, 32'h0fffffff, 32'hffffffff, 0, 0, 1, 0); cycle();
    chk("slt0_res", result_out, 32'h0);
    chk("slt0_zero", zero_out, 1);
    drive(0, 2'd0, 0, 0, 0, 0, 0, 1, 0); cycle();

    drive(1, 2'd0, 0, 32'h1234, 32'h1, 0, 0, 1, 0); cycle();
    held_res = result_out;
    held_cnt = op_count_out;
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'd1, 0, $urandom, $urandom, 0, 0, 0, 0); cycle();
      chk("bp_ready", ready_out, 0);
      chk("bp_hold", result_out, held_res);
      chk("bp_count", op_count_out, held_cnt);
    end
    drive(0, 2'd0, 0, 0, 0, 0, 0, 1, 0); cycle();
    chk("bp_release", op_count_out, held_cnt + CW'(1));
    chk("bp_ready1", ready_out, 1);

    drive(1, 2'd2, 6'h07, 32'h100, 32'h23, 0, 0, 0, 0); cycle();
    chk("ill_flag", illegal_out, 1);
    chk("ill_res", result_out, 32'h123);
    held_cnt = op_count_out;
    drive(1, 2'd0, 0, 32'h9, 32'h9, 0, 0, 0, 1); cycle();
    chk("flush_valid", valid_out, 0);
    chk("flush_count", op_count_out, held_cnt);
    drive(0, 2'd0, 0, 0, 0, 0, 0, 1, 0); cycle();

    drive(1, 2'd0, 0, 32'h7, 32'h8, 0, 0, 0, 0); cycle();
    drive(0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", valid_out, 0);
    chk("arst_result", result_out, 0);
    chk("arst_zero", zero_out, 0);
    chk("arst_illegal", illegal_out, 0);
    chk("arst_count", op_count_out, 0);
    chk("arst_ready", ready_out, 1);
    m_valid = 0; m_res = 0; m_zero = 0; m_ill = 0; m_count = 0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    drive(1, 2'd1, 0, 32'h10, 32'h3, 0, 0, 1, 0); cycle();
    chk("post_rst_res", result_out, 32'hd);

    for (int i = 0; i < 800; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0) ? 6'($urandom) : fsel[$urandom_range(0, 5)],
            a, b, 16'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Execute stage wrapped around the existing 32-bit `alu` (ports `a_in`, `b_in`, `control`, `result_out`, `zero_out`).
- Accepts decoded operands and ALUOp/funct from the decode stage over a valid/ready handshake.
- Generates the 3-bit ALU control word and selects operand B (register or sign-extended immediate).
- Registers the ALU result into a single-entry output buffer feeding the memory stage.
- Provides backpressure, flush and an op counter.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported, matching `alu`.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- valid_in  input  1  upstream has a valid op.
- ready_out  output  1  stage can accept an op this cycle.
- alu_op_in  input  2  00 = load/store add, 01 = branch sub, 10 = R-type, use funct, 11 = reserved.
- funct_in  input  6  R-type function field.
- rs_in  input  WIDTH  operand A.
- rt_in  input  WIDTH  register operand B.
- imm_in  input  16  immediate, sign-extended internally.
- alu_src_in  input  1  1 = use the sign-extended immediate as B.
- flush_in  input  1  synchronous discard of the buffered result.
- valid_out  output  1  result buffer holds a valid result.
- ready_in  input  1  downstream accepts the result.
- result_out  output  WIDTH  registered ALU result.
- zero_out  output  1  registered ALU zero flag.
- illegal_out  output  1  registered flag: the op had an undefined ALUOp/funct.
- op_count_out  output  CNT_W  number of results accepted downstream.

Behaviour:
- Reset state: when rst=1 at any time, all registered outputs are 0 immediately (`valid_out`, `result_out`, `zero_out`, `illegal_out`, `op_count_out`). `ready_out` therefore reads 1.
- Control decode (combinational):
  - ALUOp 00 → 010 (add).
  - ALUOp 01 → 110 (sub).
  - ALUOp 10, funct 100000 → 010.
  - ALUOp 10, funct 100010 → 110.
  - ALUOp 10, funct 100100 → 000.
  - ALUOp 10, funct 100101 → 001.
  - ALUOp 10, funct 101010 → 111 (set-on-less-than, signed).
  - Any other funct under ALUOp 10, or ALUOp 11 → control 010 and illegal=1. The result is still computed and buffered; it is never dropped.
- Operand B: `alu_src_in` ? {{16{imm_in[15]}}, imm_in} : `rt_in`.
- `ready_out` = !`valid_out` || `ready_in` (combinational; pass-through allowed in the same cycle).
- Buffer states:
  - EMPTY (`valid_out`=0): accept when `valid_in` && `ready_out` → FULL next cycle. `result_out`, `zero_out` and `illegal_out` load from the ALU and decode.
  - FULL (`valid_out`=1):
    - `ready_in`=1 with no new op → EMPTY.
    - `ready_in`=1 with `valid_in`=1 → stay FULL, load the new result (back-to-back, 1 op/cycle).
    - `ready_in`=0 → hold all outputs stable; `ready_out`=0.
- Latency: exactly 1 cycle from accept to `valid_out`.
- Hold rule: while `valid_out`=1 && `ready_in`=0, data outputs must not change.
- `op_count_out`:
  - Increments by 1 on each cycle with `valid_out` && `ready_in`.
  - Wraps from 2^CNT_W−1 to 0.
  - Is not cleared by flush.
- Flush (`flush_in`=1):
  - Next state is EMPTY and `valid_out`=0; a simultaneous `valid_in` is discarded.
  - A handshake in the same cycle (`valid_out` && `ready_in`) still counts.
  - Data registers may retain stale values.
- Reset mid-operation: any buffered result is lost and the counter clears; the first accept after rst deasserts behaves as from EMPTY.
- Arithmetic: add/sub are modulo 2^32 with no overflow flag. slt yields 1 or 0 zero-extended. zero = (result == 0).
- The block instantiates `alu` unchanged; the decode drives its `control` input.

Test Plan:
- ADD: alu_op=00, rs=00ff00ff, rt=11111111, alu_src=0, `valid_in` for 1 cycle, `ready_in`=1 → next cycle `valid_out`=1, result=12101210, zero=0, illegal=0; count=1 after the handshake.
- SUB/zero and immediate: alu_op=01, rs=0, rt=1 → result=ffffffff, zero=0. Then alu_op=00, rs=5, imm=fffb, alu_src=1 → result=0, zero=1.
- R-type sweep, back-to-back over 4 consecutive cycles, `ready_in`=1:
  - AND 0f0f0f0f & ffffffff → 0f0f0f0f.
  - OR 0f0f0f0f | f0f0f0f0 → ffffffff.
  - SLT ffffffff < 0fffffff → 1.
  - SLT 0fffffff < ffffffff → 0.
  - Expect one result per cycle, in order.
- Backpressure: hold `ready_in`=0 for 3 cycles with a result buffered → `ready_out`=0, outputs stable, count unchanged; raise `ready_in` → count increments by 1, `ready_out`=1.
- Illegal and flush:
  - funct=000111 under alu_op=10 → illegal_out=1, result = rs+rt.
  - Assert `flush_in` while FULL and `ready_in`=0 → `valid_out`=0 next cycle, count unchanged.
- Reset: assert rst asynchronously mid-cycle with FULL and count=5 → all outputs 0 before the next clock edge; normal operation resumes after deassertion.
